// File: rtl/tt_exhaustive_checker.sv
// Exhaustive 3-input truth-table checker: walks {A,B,C} through 000..111 and scores three unit responses.
// Optional build macro TT_EARLY_ABORT_EN stops the run at the first vector with any mismatch.
module tt_exhaustive_checker #(
  parameter logic [7:0]  EXPECTED      = 8'hEA,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A,
  output logic       B,
  output logic       C,
  input  logic       F_structural,
  input  logic       F_functional,
  input  logic       F_behavioral,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_count,
  output logic [2:0] first_fail_vec,
  output logic       first_fail_valid
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  function automatic logic [1:0] mismatch_count(input logic [2:0] f, input logic expect_bit);
    logic [2:0] diff;
    diff = f ^ {3{expect_bit}};
    return {1'b0, diff[0]} + {1'b0, diff[1]} + {1'b0, diff[2]};
  endfunction

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [4:0] err_q, err_d;
  logic [2:0] ffv_q, ffv_d;
  logic       ffvalid_q, ffvalid_d;
  logic       pass_q, pass_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [2:0] f_q;
  logic [1:0] miss_cnt_s;
  logic       abort_s;

  // Responses are captured on the edge that ends the settle window and scored during SAMPLE.
  assign miss_cnt_s = mismatch_count(f_q, EXPECTED[vec_q]);

`ifdef TT_EARLY_ABORT_EN
  assign abort_s = (miss_cnt_s != 2'd0);
`else
  assign abort_s = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      vec_q     <= 3'd0;
      cnt_q     <= 4'd0;
      err_q     <= 5'd0;
      ffv_q     <= 3'd0;
      ffvalid_q <= 1'b0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      f_q       <= 3'd0;
    end else begin
      state_q   <= state_d;
      vec_q     <= vec_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      ffv_q     <= ffv_d;
      ffvalid_q <= ffvalid_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      f_q       <= {F_structural, F_functional, F_behavioral};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = S_SETTLE;
        else       state_d = state_q;
      end
      S_SETTLE: begin
        if (cnt_q == 4'd0) state_d = S_SAMPLE;
        else               state_d = S_SETTLE;
      end
      S_SAMPLE: begin
        if (vec_q == 3'd7 || abort_s) state_d = S_DONE;
        else                          state_d = S_SETTLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vec_d     = vec_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ffv_d     = ffv_q;
    ffvalid_d = ffvalid_q;
    pass_d    = pass_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d     = 3'd0;
          cnt_d     = SETTLE_LOAD;
          err_d     = 5'd0;
          ffv_d     = 3'd0;
          ffvalid_d = 1'b0;
          pass_d    = 1'b0;
        end else begin
          vec_d = vec_q;
        end
      end
      S_SETTLE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else               cnt_d = cnt_q;
      end
      S_SAMPLE: begin
        err_d = err_q + {3'd0, miss_cnt_s};
        if (miss_cnt_s != 2'd0 && !ffvalid_q) begin
          ffv_d     = vec_q;
          ffvalid_d = 1'b1;
        end else begin
          ffv_d = ffv_q;
        end
        // The DONE vector stays on the last one driven (111, or the failing one on abort).
        if (state_d == S_SETTLE) begin
          vec_d = vec_q + 3'd1;
          cnt_d = SETTLE_LOAD;
        end else begin
          vec_d = vec_q;
        end
        pass_d = (state_d == S_DONE) && (err_d == 5'd0);
      end
      default: begin
        vec_d = vec_q;
      end
    endcase
  end

  always_comb begin
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
    done_d = (state_d == S_DONE);
  end

  assign A                = vec_q[2];
  assign B                = vec_q[1];
  assign C                = vec_q[0];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign err_count        = err_q;
  assign first_fail_vec   = ffv_q;
  assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_tt_exhaustive_checker.sv
// Table-driven bench for tt_exhaustive_checker with a behavioural 3-input unit and injectable faults.
module tb_tt_exhaustive_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       A, B, C;
  logic       fs, ff, fb;
  logic       busy, done, pass;
  logic [4:0] err_count;
  logic [2:0] first_fail_vec;
  logic       first_fail_valid;

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;
  logic g_s;

  typedef struct {
    int fault;
    int poke;
    int vec_walk;
    int exp_lat;
    int exp_err;
    int exp_pass;
    int exp_ffvalid;
    int exp_ffv;
    int exp_abc;
  } tv_t;

  tv_t tv[$];

  tt_exhaustive_checker #(.EXPECTED(8'hEA), .SETTLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A(A), .B(B), .C(C),
    .F_structural(fs), .F_functional(ff), .F_behavioral(fb),
    .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_vec(first_fail_vec),
    .first_fail_valid(first_fail_valid)
  );

  always #5 clk = ~clk;

  // Unit under test: F = (A&B)|C with selectable faults.
  assign g_s = (A & B) | C;
  always_comb begin
    fs = g_s;
    ff = g_s;
    fb = g_s;
    case (fault_mode)
      1: fs = 1'b0;
      2: begin fs = ~g_s; ff = ~g_s; fb = ~g_s; end
      3: ff = 1'b1;
      default: ;
    endcase
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_ffv"}, first_fail_vec, 0);
    check({tag, "_ffvalid"}, first_fail_valid, 0);
    check({tag, "_abc"}, {A, B, C}, 0);
  endtask

  task automatic run_row(input tv_t t);
    int n;
    fault_mode = t.fault;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    check("accept_busy", busy, 1);
    check("accept_done_clr", done, 0);
    check("accept_err_clr", err_count, 0);
    n = 0;
    while (!done && n < 200) begin
      if (t.vec_walk != 0) check("vec_walk", {A, B, C}, n / 5);
      start = (t.poke != 0) && (n == 12 || n == 27);
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    check("done_latency", n, t.exp_lat);
    check("busy_at_done", busy, 0);
    check("pass", pass, t.exp_pass);
    check("err_count", err_count, t.exp_err);
    check("ff_valid", first_fail_valid, t.exp_ffvalid);
    check("ff_vec", first_fail_vec, t.exp_ffv);
    check("abc_at_done", {A, B, C}, t.exp_abc);
    repeat (3) @(posedge clk);
    #1 check("done_held", done, 1);
  endtask

  initial begin
    // fault, poke, walk, latency, err, pass, ffvalid, ffvec, abc
    tv.push_back('{0, 0, 1, 40, 0, 1, 0, 0, 7});
`ifdef TT_EARLY_ABORT_EN
    tv.push_back('{3, 0, 0, 5, 1, 0, 1, 0, 0});
    tv.push_back('{1, 0, 0, 10, 1, 0, 1, 1, 1});
    tv.push_back('{2, 0, 0, 5, 3, 0, 1, 0, 0});
`else
    tv.push_back('{1, 0, 0, 40, 5, 0, 1, 1, 7});
    tv.push_back('{2, 0, 0, 40, 24, 0, 1, 0, 7});
    tv.push_back('{3, 0, 0, 40, 3, 0, 1, 0, 7});
`endif
    tv.push_back('{0, 1, 1, 40, 0, 1, 0, 0, 7});
    tv.push_back('{0, 0, 0, 40, 0, 1, 0, 0, 7});

    rst = 1'b1;
    start = 1'b0;
    #12 check_reset_values("reset");
    @(negedge clk) rst = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("idle_no_start_busy", busy, 0);
    check("idle_no_start_abc", {A, B, C}, 0);

    for (int i = 0; i < tv.size(); i++) run_row(tv[i]);

    // Reset mid-run at cycle 17 with a faulty unit so partial counts are nonzero.
    fault_mode = 2;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (17) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_values("midrun_rst");
    @(negedge clk) rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    check("post_rst_abc", {A, B, C}, 0);
    check("post_rst_err", err_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
